przesuniecie_lewo_sekw: RTL and testbench

// - Sequential arithmetic LEFT shift of i_arg_A by N = ~i_arg_B bits (same ~B encoding as the right shifter).
// - Shifts one bit per clock under a start/valid handshake; counterpart to the combinational right shifter.
// - Sits in the synchronous arithmetic unit as the multi-cycle shift-left operation.
// - Reports error and overflow flags with the result.

---
 rtl/przesuniecie_lewo_sekw.sv | 159 +++++++++++++++
 tb/tb_przesuniecie_lewo_sekw.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/przesuniecie_lewo_sekw.sv
// Sequential arithmetic left shift of i_arg_A by N = ~i_arg_B, one bit per clock.
// Define SHIFT_SATURATE_EN to saturate o_result by the operand sign on overflow.
module przesuniecie_lewo_sekw #(
  parameter int BITS = 32
) (
  input  logic            i_clk,
  input  logic            i_rsn,
  input  logic            i_start,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  output logic            o_busy,
  output logic            o_valid,
  output logic [BITS-1:0] o_result,
  output logic            o_error,
  output logic            o_overflow
);

  localparam int CW = $clog2(BITS) + 1;
  localparam logic [BITS-1:0] N_LIMIT = {{(BITS-CW){1'b0}}, CW'(BITS)};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [BITS-1:0] shreg_r, shreg_s;
  logic            ovf_r, ovf_s, ovf_next_s;
  logic [BITS-1:0] n_s;
  logic            busy_s, valid_s, error_s, overflow_s;
  logic [BITS-1:0] result_s;

`ifdef SHIFT_SATURATE_EN
  logic sign_r, sign_s;

  function automatic logic [BITS-1:0] sat_value(input logic neg);
    sat_value = neg ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
  endfunction
`endif

  assign n_s = ~i_arg_B;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    shreg_s    = shreg_r;
    ovf_s      = ovf_r;
    ovf_next_s = ovf_r;
    busy_s     = 1'b0;
    valid_s    = 1'b0;
    result_s   = o_result;
    error_s    = o_error;
    overflow_s = o_overflow;
`ifdef SHIFT_SATURATE_EN
    sign_s     = sign_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
`ifdef SHIFT_SATURATE_EN
          sign_s = i_arg_A[BITS-1];
`endif
          if (n_s[BITS-1]) begin
            state_s    = ST_DONE;
            valid_s    = 1'b1;
            result_s   = {BITS{1'b0}};
            error_s    = 1'b1;
            overflow_s = 1'b0;
          end else if (n_s == {BITS{1'b0}}) begin
            state_s    = ST_DONE;
            valid_s    = 1'b1;
            result_s   = i_arg_A;
            error_s    = 1'b0;
            overflow_s = 1'b0;
          end else if (n_s >= N_LIMIT) begin
            state_s    = ST_DONE;
            valid_s    = 1'b1;
            error_s    = 1'b0;
            overflow_s = (i_arg_A != {BITS{1'b0}});
`ifdef SHIFT_SATURATE_EN
            result_s   = overflow_s ? sat_value(i_arg_A[BITS-1]) : {BITS{1'b0}};
`else
            result_s   = {BITS{1'b0}};
`endif
          end else begin
            state_s = ST_SHIFT;
            busy_s  = 1'b1;
            cnt_s   = n_s[CW-1:0];
            shreg_s = i_arg_A;
            ovf_s   = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Overflow is judged on the two top bits before each shift.
        ovf_next_s = ovf_r | (shreg_r[BITS-1] ^ shreg_r[BITS-2]);
        ovf_s      = ovf_next_s;
        shreg_s    = {shreg_r[BITS-2:0], 1'b0};
        cnt_s      = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_s    = ST_DONE;
          valid_s    = 1'b1;
          error_s    = 1'b0;
          overflow_s = ovf_next_s;
`ifdef SHIFT_SATURATE_EN
          result_s   = ovf_next_s ? sat_value(sign_r) : shreg_s;
`else
          result_s   = shreg_s;
`endif
        end else begin
          busy_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rsn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      shreg_r    <= {BITS{1'b0}};
      ovf_r      <= 1'b0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_result   <= {BITS{1'b0}};
      o_error    <= 1'b0;
      o_overflow <= 1'b0;
`ifdef SHIFT_SATURATE_EN
      sign_r     <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      shreg_r    <= shreg_s;
      ovf_r      <= ovf_s;
      o_busy     <= busy_s;
      o_valid    <= valid_s;
      o_result   <= result_s;
      o_error    <= error_s;
      o_overflow <= overflow_s;
`ifdef SHIFT_SATURATE_EN
      sign_r     <= sign_s;
`endif
    end
  end

endmodule

// File: tb/tb_przesuniecie_lewo_sekw.sv
// Directed bench for przesuniecie_lewo_sekw (BITS=32): results, flags, latency,
// ignored starts and reset abort.
module tb_przesuniecie_lewo_sekw;

  logic        clk = 1'b0;
  logic        i_rsn, i_start;
  logic [31:0] i_arg_A, i_arg_B;
  logic        o_busy, o_valid, o_error, o_overflow;
  logic [31:0] o_result;
  int          total = 0;
  int          bad = 0;

`ifdef SHIFT_SATURATE_EN
  localparam logic [31:0] EXP_V2 = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_V5 = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_V8 = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_V9 = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_V2 = 32'h8000_0000;
  localparam logic [31:0] EXP_V5 = 32'h0000_0000;
  localparam logic [31:0] EXP_V8 = 32'h8000_0000;
  localparam logic [31:0] EXP_V9 = 32'h0000_0000;
`endif

  przesuniecie_lewo_sekw #(.BITS(32)) dut (
    .i_clk(clk), .i_rsn(i_rsn), .i_start(i_start),
    .i_arg_A(i_arg_A), .i_arg_B(i_arg_B),
    .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result),
    .o_error(o_error), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_err, input logic exp_ovf);
    int lat;
    int busy_n;
    @(negedge clk);
    i_start = 1'b1; i_arg_A = a; i_arg_B = b;
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 0; busy_n = 0;
    while (o_valid !== 1'b1 && lat < 100) begin
      if (o_busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/lat"},  32'(lat), 32'(exp_lat));
    chk({tag, "/busyn"}, 32'(busy_n), 32'(exp_lat));
    chk({tag, "/res"},  o_result, exp_res);
    chk({tag, "/err"},  {31'd0, o_error}, {31'd0, exp_err});
    chk({tag, "/ovf"},  {31'd0, o_overflow}, {31'd0, exp_ovf});
    chk({tag, "/busy"}, {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "/vdrop"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "/hold"}, o_result, exp_res);
  endtask

  initial begin
    int lat;
    int nv;
    i_rsn = 1'b0; i_start = 1'b0; i_arg_A = 32'd0; i_arg_B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/busy", {31'd0, o_busy}, 32'd0);
    chk("rst/valid", {31'd0, o_valid}, 32'd0);
    chk("rst/res", o_result, 32'd0);
    chk("rst/flags", {30'd0, o_error, o_overflow}, 32'd0);
    @(negedge clk); i_rsn = 1'b1;

    run_op("n3",     32'h0000_0001, 32'hFFFF_FFFC, 3,  32'h0000_0008, 1'b0, 1'b0);
    run_op("n1ovf",  32'h4000_0000, 32'hFFFF_FFFE, 1,  EXP_V2,        1'b0, 1'b1);
    run_op("n0",     32'h1234_5678, 32'hFFFF_FFFF, 0,  32'h1234_5678, 1'b0, 1'b0);
    run_op("nneg",   32'h1234_5678, 32'h0000_0000, 0,  32'h0000_0000, 1'b1, 1'b0);
    run_op("n40",    32'h1234_5678, ~32'd40,       0,  EXP_V5,        1'b0, 1'b1);
    run_op("n32z",   32'h0000_0000, ~32'd32,       0,  32'h0000_0000, 1'b0, 1'b0);
    run_op("n31neg", 32'hFFFF_FFFF, ~32'd31,       31, 32'h8000_0000, 1'b0, 1'b0);
    run_op("n31ovf", 32'h0000_0003, ~32'd31,       31, EXP_V8,        1'b0, 1'b1);
    run_op("n2neg",  32'h8000_0000, ~32'd2,        2,  EXP_V9,        1'b0, 1'b1);

    // start held into the o_valid cycle must not launch a second operation
    @(negedge clk);
    i_start = 1'b1; i_arg_A = 32'h0000_0007; i_arg_B = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("vcyc/valid", {31'd0, o_valid}, 32'd1);
    chk("vcyc/res", o_result, 32'h0000_0007);
    i_arg_A = 32'h0000_0009;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("vcyc/ign", {31'd0, o_valid}, 32'd0);
    chk("vcyc/hold", o_result, 32'h0000_0007);
    @(posedge clk); #1;

    // N=10 with a second start pulse while busy
    @(negedge clk);
    i_start = 1'b1; i_arg_A = 32'h0000_0001; i_arg_B = ~32'd10;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); i_start = 1'b1; i_arg_A = 32'h0000_00FF; i_arg_B = ~32'd1;
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 3;
    while (o_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n10/lat", 32'(lat), 32'd10);
    chk("n10/res", o_result, 32'h0000_0400);
    nv = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_valid === 1'b1) nv++;
    end
    chk("n10/extra", 32'(nv), 32'd0);

    // reset in the middle of a shift aborts it
    @(negedge clk);
    i_start = 1'b1; i_arg_A = 32'h0000_0001; i_arg_B = ~32'd10;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort/busy_pre", {31'd0, o_busy}, 32'd1);
    @(negedge clk); i_rsn = 1'b0;
    @(posedge clk); #1;
    chk("abort/busy", {31'd0, o_busy}, 32'd0);
    chk("abort/res", o_result, 32'd0);
    chk("abort/flags", {30'd0, o_error, o_overflow}, 32'd0);
    @(negedge clk); i_rsn = 1'b1;
    nv = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (o_valid === 1'b1) nv++;
    end
    chk("abort/novalid", 32'(nv), 32'd0);
    run_op("fresh", 32'h0000_0005, ~32'd2, 2, 32'h0000_0014, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
